vector_issue_queue: RTL and testbench

VECTOR_ISSUE_QUEUE -- requirements
Module: vector_issue_queue

---
 rtl/vector_issue_queue_pkg.sv | 75 +++++++
 rtl/viq_fifo.sv | 58 +++++
 rtl/vector_issue_queue.sv | 202 ++++++++++++++++++++
 tb/tb_vector_issue_queue.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_issue_queue_pkg.sv
// Shared types for vector_issue_queue: opcodes, funct3/mop codes,
// queue entry layout and one-hot issue-unit vectors.
package vector_issue_queue_pkg;

   localparam int VIQ_UNITS = 11;

   typedef logic [VIQ_UNITS-1:0] unit_vec_t;

   typedef enum logic [6:0] {
      OPC_LOAD  = 7'b0000111,
      OPC_STORE = 7'b0100111,
      OPC_ARITH = 7'b1010111
   } opcode_e;

   typedef enum logic [2:0] {
      F3_OPIVV = 3'b000,
      F3_OPFVV = 3'b001,
      F3_OPMVV = 3'b010,
      F3_OPIVI = 3'b011,
      F3_OPIVX = 3'b100,
      F3_OPFVF = 3'b101,
      F3_OPMVX = 3'b110,
      F3_OPCFG = 3'b111
   } funct3_e;

   typedef enum logic [1:0] {
      MOP_UNIT      = 2'b00,
      MOP_IDX_UNORD = 2'b01,
      MOP_STRIDED   = 2'b10,
      MOP_IDX_ORD   = 2'b11
   } mop_e;

   localparam unit_vec_t OPIVV_vld        = 11'b000_0000_0001;
   localparam unit_vec_t OPIVI_vld        = 11'b000_0000_0001;
   localparam unit_vec_t OPIVX_vld        = 11'b000_0000_0001;
   localparam unit_vec_t OPFVV_vld        = 11'b000_0000_0010;
   localparam unit_vec_t OPFVF_vld        = 11'b000_0000_0010;
   localparam unit_vec_t OPMVV_vld        = 11'b000_0000_0100;
   localparam unit_vec_t OPMVX_vld        = 11'b000_0000_1000;
   localparam unit_vec_t OPMVV_101xxx_vld = 11'b000_0001_0000;
   localparam unit_vec_t OPMVX_101xxx_vld = 11'b000_0010_0000;
   localparam unit_vec_t OPCFG_vld        = 11'b000_0100_0000;
   localparam unit_vec_t LOAD_vld         = 11'b000_1000_0000;
   localparam unit_vec_t LOAD_IDX_vld     = 11'b001_0000_0000;
   localparam unit_vec_t STORE_vld        = 11'b010_0000_0000;
   localparam unit_vec_t STORE_IDX_vld    = 11'b100_0000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [1:0]  sew;
   } viq_entry_t;

   // Arithmetic class to unit; f6_hi is funct6[5:3].
   function automatic unit_vec_t arith_vld(
      input logic [2:0] f3,
      input logic [2:0] f6_hi
   );
      unit_vec_t v;
      v = '0;
      case (f3)
         F3_OPIVV: v = OPIVV_vld;
         F3_OPIVI: v = OPIVI_vld;
         F3_OPIVX: v = OPIVX_vld;
         F3_OPFVV: v = OPFVV_vld;
         F3_OPFVF: v = OPFVF_vld;
         F3_OPMVV: v = (f6_hi == 3'b101) ? OPMVV_101xxx_vld : OPMVV_vld;
         F3_OPMVX: v = (f6_hi == 3'b101) ? OPMVX_101xxx_vld : OPMVX_vld;
         default:  v = OPCFG_vld;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/viq_fifo.sv
// Circular entry store for vector_issue_queue.
// Power-of-two depth, pointers wrap naturally; no read bypass.
module viq_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Entry storage; data needs no reset
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

   // Next pointer and occupancy values
   always_comb begin
      wptr_d = wptr_q + AW'(do_push);
      rptr_d = rptr_q + AW'(do_pop);
      cnt_d  = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/vector_issue_queue.sv
// Vector instruction queue issuing to arithmetic units and the MCU.
// Macro VIQ_IDX_LD_SPLIT_EN splits unordered indexed loads in two.
module vector_issue_queue
   import vector_issue_queue_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int NUM_UNITS = 11
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [31:0]               vector_instr_i,
   input  logic                      vector_instr_vld_i,
   input  logic [31:0]               rs1_i,
   input  logic [31:0]               rs2_i,
   input  logic [1:0]                sew_i,
   output logic                      vector_stall_o,
   output logic [$clog2(DEPTH):0]    q_count_o,
   output logic                      illegal_o,
   output logic [NUM_UNITS-1:0]      instr_vld_o,
   input  logic [NUM_UNITS-1:0]      instr_rdy_i,
   output logic [31:0]               vector_instr_o,
   output logic [31:0]               rs1_o,
   output logic                      mcu_ld_vld_o,
   input  logic                      mcu_ld_rdy_i,
   input  logic                      mcu_ld_buffered_i,
   output logic                      mcu_st_vld_o,
   input  logic                      mcu_st_rdy_i,
   output logic [31:0]               mcu_base_addr_o,
   output logic [31:0]               mcu_stride_o,
   output logic [2:0]                mcu_data_width_o,
   output logic                      mcu_idx_ld_st_o,
   output logic                      mcu_strided_ld_st_o,
   output logic                      mcu_unit_ld_st_o
);

`ifdef VIQ_IDX_LD_SPLIT_EN
   localparam bit SplitEn = 1'b1;
`else
   localparam bit SplitEn = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_ISSUE   = 2'd0,
      S_LD_WAIT = 2'd1,
      S_IDX2    = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic       buf_q, buf_d;
   logic       split_q, split_d;

   viq_entry_t wr_e, hd_e;
   logic       full, empty, push, pop;

   logic [31:0] idx2_word, cur_word;
   logic [6:0]  opc;
   logic [1:0]  mop;
   logic        is_ar, is_st, is_ldu, is_ldi;
   logic        split_take, acc;

   logic [NUM_UNITS-1:0] vld_sel;
   logic                 ld_vld, st_vld, illegal;

   assign wr_e = '{instr: vector_instr_i, rs1: rs1_i,
                   rs2: rs2_i, sew: sew_i};
   assign push = vector_instr_vld_i && !full;

   viq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(viq_entry_t))
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wr_e),
      .rdata_o (hd_e),
      .full_o  (full),
      .empty_o (empty),
      .count_o (q_count_o)
   );

   assign vector_stall_o = full;

   // Second half of a split indexed load runs as a unit load
   assign idx2_word = {hd_e.instr[31:28], 2'b00,
                       hd_e.instr[25:15], 1'b0, hd_e.sew,
                       hd_e.instr[11:0]};
   assign cur_word = (state_q == S_IDX2 || split_q)
                   ? idx2_word : hd_e.instr;

   assign opc    = cur_word[6:0];
   assign mop    = cur_word[27:26];
   assign is_ar  = (opc == OPC_ARITH);
   assign is_st  = (opc == OPC_STORE);
   assign is_ldu = (opc == OPC_LOAD) && !mop[0];
   assign is_ldi = (opc == OPC_LOAD) && mop[0];

   assign split_take = SplitEn && is_ldi && (mop == MOP_IDX_UNORD);
   assign acc        = |(vld_sel & instr_rdy_i);

   // State and buffered-data flag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_ISSUE;
         buf_q   <= 1'b0;
         split_q <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         split_q <= split_d;
      end
   end

   // Next state from MCU handshake and unit acceptance
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      split_d = split_q;
      unique case (state_q)
         S_LD_WAIT: begin
            if (mcu_ld_buffered_i) buf_d = 1'b1;
            if (acc) begin
               state_d = S_ISSUE;
               buf_d   = 1'b0;
               split_d = 1'b0;
            end
         end
         default: begin
            if (ld_vld && mcu_ld_rdy_i) begin
               state_d = S_LD_WAIT;
               buf_d   = mcu_ld_buffered_i;
               split_d = (state_q == S_IDX2);
            end else if (acc && split_take) begin
               state_d = S_IDX2;
            end
         end
      endcase
   end

   // Issue valids, MCU request valids and illegal pulse
   always_comb begin
      vld_sel = '0;
      ld_vld  = 1'b0;
      st_vld  = 1'b0;
      illegal = 1'b0;
      if (!empty) begin
         unique case (state_q)
            S_LD_WAIT: begin
               if (buf_q || mcu_ld_buffered_i)
                  vld_sel = NUM_UNITS'(LOAD_vld);
            end
            default: begin
               unique case (1'b1)
                  is_ar: begin
                     vld_sel = NUM_UNITS'(arith_vld(
                        cur_word[14:12], cur_word[31:29]));
                  end
                  is_st: begin
                     st_vld = (mop != MOP_IDX_UNORD);
                     if (mcu_st_rdy_i)
                        vld_sel = mop[0]
                                ? NUM_UNITS'(STORE_IDX_vld)
                                : NUM_UNITS'(STORE_vld);
                  end
                  is_ldu: ld_vld = 1'b1;
                  is_ldi: vld_sel = NUM_UNITS'(LOAD_IDX_vld);
                  default: illegal = 1'b1;
               endcase
            end
         endcase
      end
   end

   // Head retirement
   always_comb begin
      pop = 1'b0;
      if (!empty) begin
         if (state_q == S_LD_WAIT) pop = acc;
         else pop = illegal || (acc && !split_take);
      end
   end

   assign instr_vld_o  = vld_sel;
   assign mcu_ld_vld_o = ld_vld;
   assign mcu_st_vld_o = st_vld;
   assign illegal_o    = illegal;

   assign vector_instr_o   = empty ? '0 : cur_word;
   assign rs1_o            = empty ? '0 : hd_e.rs1;
   assign mcu_base_addr_o  = rs1_o;
   assign mcu_stride_o     = empty ? '0 : hd_e.rs2;
   assign mcu_data_width_o = vector_instr_o[14:12];

   assign mcu_idx_ld_st_o = !empty && (is_st || is_ldu || is_ldi)
                          && mop[0];
   assign mcu_strided_ld_st_o = !empty && (is_st || is_ldu || is_ldi)
                              && (mop == MOP_STRIDED);
   assign mcu_unit_ld_st_o = !empty && (is_st || is_ldu || is_ldi)
                           && (mop == MOP_UNIT);

endmodule

// File: tb/tb_vector_issue_queue.sv
// Bench for vector_issue_queue: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_vector_issue_queue;

  localparam int DEPTH = 4;
  localparam int NU    = 11;

  localparam logic [6:0] LDO = 7'b0000111;
  localparam logic [6:0] STO = 7'b0100111;
  localparam logic [6:0] ARO = 7'b1010111;

  localparam int B_LD  = 7;
  localparam int B_LDI = 8;
  localparam int B_ST  = 9;
  localparam int B_STI = 10;

  logic clk = 0;
  logic rst = 1;
  logic [31:0] vector_instr_i = 0;
  logic vector_instr_vld_i = 0;
  logic [31:0] rs1_i = 0, rs2_i = 0;
  logic [1:0] sew_i = 0;
  logic vector_stall_o;
  logic [$clog2(DEPTH):0] q_count_o;
  logic illegal_o;
  logic [NU-1:0] instr_vld_o;
  logic [NU-1:0] instr_rdy_i = 0;
  logic [31:0] vector_instr_o, rs1_o;
  logic mcu_ld_vld_o, mcu_ld_rdy_i = 0, mcu_ld_buffered_i = 0;
  logic mcu_st_vld_o, mcu_st_rdy_i = 0;
  logic [31:0] mcu_base_addr_o, mcu_stride_o;
  logic [2:0] mcu_data_width_o;
  logic mcu_idx_ld_st_o, mcu_strided_ld_st_o, mcu_unit_ld_st_o;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  s;
  } ent_t;

  ent_t mq[$];
  bit m_wait = 0;
  bit m_data = 0;
  bit m_half = 0;

`ifdef VIQ_IDX_LD_SPLIT_EN
  localparam bit SPLIT = 1;
`else
  localparam bit SPLIT = 0;
`endif

  always #5 clk = ~clk;

  vector_issue_queue #(.DEPTH(DEPTH), .NUM_UNITS(NU)) dut (
    .clk(clk), .rst(rst),
    .vector_instr_i(vector_instr_i),
    .vector_instr_vld_i(vector_instr_vld_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .sew_i(sew_i),
    .vector_stall_o(vector_stall_o),
    .q_count_o(q_count_o),
    .illegal_o(illegal_o),
    .instr_vld_o(instr_vld_o),
    .instr_rdy_i(instr_rdy_i),
    .vector_instr_o(vector_instr_o),
    .rs1_o(rs1_o),
    .mcu_ld_vld_o(mcu_ld_vld_o),
    .mcu_ld_rdy_i(mcu_ld_rdy_i),
    .mcu_ld_buffered_i(mcu_ld_buffered_i),
    .mcu_st_vld_o(mcu_st_vld_o),
    .mcu_st_rdy_i(mcu_st_rdy_i),
    .mcu_base_addr_o(mcu_base_addr_o),
    .mcu_stride_o(mcu_stride_o),
    .mcu_data_width_o(mcu_data_width_o),
    .mcu_idx_ld_st_o(mcu_idx_ld_st_o),
    .mcu_strided_ld_st_o(mcu_strided_ld_st_o),
    .mcu_unit_ld_st_o(mcu_unit_ld_st_o)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [NU-1:0] onehot(input int b);
    logic [NU-1:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  // Unit for an arithmetic word, from funct3 and funct6
  function automatic logic [NU-1:0] cls(input logic [31:0] w);
    int b;
    bit hi;
    hi = (w[31:29] == 3'b101);
    case (w[14:12])
      3'd0, 3'd3, 3'd4: b = 0;
      3'd1, 3'd5:       b = 1;
      3'd2:             b = hi ? 4 : 2;
      3'd6:             b = hi ? 5 : 3;
      default:          b = 6;
    endcase
    return onehot(b);
  endfunction

  function automatic logic [31:0] rewrite(input ent_t e);
    return {e.ins[31:28], 2'b00, e.ins[25:15],
            1'b0, e.s, e.ins[11:0]};
  endfunction

  task automatic step(input bit r, input bit pv,
                      input logic [31:0] ins,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [1:0] s,
                      input logic [NU-1:0] rdy,
                      input bit lrdy, input bit lbuf,
                      input bit srdy);
    logic [NU-1:0] e_vld;
    logic [31:0] w, e_w, e_a, e_b;
    logic [6:0] op;
    logic [1:0] mp;
    bit e_ld, e_st, e_ill, e_idx, e_str, e_unit;
    bit pop, acc;
    int n;
    ent_t h, ne;
    @(negedge clk);
    rst = r;
    vector_instr_vld_i = pv;
    vector_instr_i = ins;
    rs1_i = a;
    rs2_i = b;
    sew_i = s;
    instr_rdy_i = rdy;
    mcu_ld_rdy_i = lrdy;
    mcu_ld_buffered_i = lbuf;
    mcu_st_rdy_i = srdy;
    #1;
    n = mq.size();
    e_vld = '0;
    {e_ld, e_st, e_ill, e_idx, e_str, e_unit} = '0;
    e_w = 0; e_a = 0; e_b = 0;
    pop = 0;
    if (n > 0) begin
      h = mq[0];
      w = m_half ? rewrite(h) : h.ins;
      e_w = w; e_a = h.a; e_b = h.b;
      op = w[6:0];
      mp = w[27:26];
      if (op == LDO || op == STO) begin
        e_idx = mp[0];
        e_str = (mp == 2'd2);
        e_unit = (mp == 2'd0);
      end
      if (m_wait) begin
        if (m_data || lbuf) e_vld = onehot(B_LD);
      end else if (op == ARO) begin
        e_vld = cls(w);
      end else if (op == STO) begin
        e_st = (mp != 2'd1);
        if (srdy) e_vld = onehot(mp[0] ? B_STI : B_ST);
      end else if (op == LDO && !mp[0]) begin
        e_ld = 1;
      end else if (op == LDO) begin
        e_vld = onehot(B_LDI);
      end else begin
        e_ill = 1;
      end
    end
    check("instr_vld", instr_vld_o, e_vld);
    check("onehot", 64'($countones(instr_vld_o) <= 1), 1);
    check("q_count", q_count_o, n);
    check("stall", vector_stall_o, n == DEPTH);
    check("illegal", illegal_o, e_ill);
    check("ld_vld", mcu_ld_vld_o, e_ld);
    check("st_vld", mcu_st_vld_o, e_st);
    check("instr_o", vector_instr_o, e_w);
    check("rs1_o", rs1_o, e_a);
    check("base", mcu_base_addr_o, e_a);
    check("stride", mcu_stride_o, e_b);
    check("width", mcu_data_width_o, e_w[14:12]);
    check("idx", mcu_idx_ld_st_o, e_idx);
    check("strided", mcu_strided_ld_st_o, e_str);
    check("unit", mcu_unit_ld_st_o, e_unit);
    if (r) begin
      mq.delete();
      m_wait = 0; m_data = 0; m_half = 0;
      return;
    end
    acc = ((e_vld & rdy) != 0);
    if (n > 0) begin
      if (m_wait) begin
        if (acc) begin
          pop = 1;
          m_wait = 0; m_data = 0; m_half = 0;
        end else if (lbuf) begin
          m_data = 1;
        end
      end else if (e_ill) begin
        pop = 1;
      end else if (e_ld) begin
        if (lrdy) begin
          m_wait = 1;
          m_data = lbuf;
        end
      end else if (acc) begin
        if (SPLIT && op == LDO && mp == 2'd1) m_half = 1;
        else pop = 1;
      end
    end
    if (pop) void'(mq.pop_front());
    if (pv && n < DEPTH) begin
      ne.ins = ins; ne.a = a; ne.b = b; ne.s = s;
      mq.push_back(ne);
    end
  endtask

  task automatic idle(input logic [NU-1:0] rdy,
                      input bit lrdy, input bit lbuf,
                      input bit srdy);
    step(0, 0, 0, 0, 0, 0, rdy, lrdy, lbuf, srdy);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: w[6:0] = ARO;
      4, 5:       w[6:0] = LDO;
      6, 7:       w[6:0] = STO;
      8:          w[6:0] = 7'h00;
      default:    w[6:0] = 7'h13;
    endcase
    return w;
  endfunction

  logic [31:0] vadd, uld, ust, ild;
  logic [NU-1:0] ones;

  initial begin
    ones = '1;
    vadd = {6'b0, 1'b1, 5'd2, 5'd1, 3'b000, 5'd3, ARO};
    uld  = {3'b000, 1'b0, 2'b00, 1'b1, 5'd0, 5'd5,
            3'b110, 5'd4, LDO};
    ust  = {3'b000, 1'b0, 2'b00, 1'b1, 5'd0, 5'd6,
            3'b101, 5'd7, STO};
    ild  = {3'b000, 1'b0, 2'b01, 1'b1, 5'd9, 5'd8,
            3'b111, 5'd2, LDO};
    @(negedge clk);
    @(negedge clk);

    // reset state
    idle(0, 0, 0, 0);
    check("rst_count", q_count_o, 0);
    check("rst_vld", instr_vld_o, 0);

    // fill with vadd.vv while units are busy
    for (int i = 0; i < 4; i++)
      step(0, 1, vadd, 32'h100 + i, 32'h200 + i, 0, 0, 0, 0, 0);
    idle(0, 0, 0, 0);
    check("full_stall", vector_stall_o, 1);
    check("full_count", q_count_o, 4);
    for (int i = 0; i < 4; i++) begin
      idle(ones, 0, 0, 0);
      check("vadd_issue", instr_vld_o, onehot(0));
      check("drain_count", q_count_o, 4 - i);
    end
    idle(0, 0, 0, 0);
    check("drain_empty", q_count_o, 0);

    // unit load: handshake, wait, buffered pulse, accept
    step(0, 1, uld, 32'h1000, 32'h4, 1, 0, 0, 0, 0);
    idle(ones, 1, 0, 0);
    check("ld_req", mcu_ld_vld_o, 1);
    check("ld_no_issue", instr_vld_o, 0);
    idle(ones, 0, 0, 0);
    check("ld_wait_req", mcu_ld_vld_o, 0);
    check("ld_wait_vld", instr_vld_o, 0);
    idle(0, 0, 0, 0);
    idle(0, 0, 1, 0);
    check("ld_buf_vld", instr_vld_o, onehot(B_LD));
    idle(ones, 0, 0, 0);
    check("ld_flag_vld", instr_vld_o, onehot(B_LD));
    idle(0, 0, 0, 0);
    check("ld_popped", q_count_o, 0);

    // store held off by MCU
    step(0, 1, ust, 32'h2000, 32'h8, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      idle(ones, 0, 0, 0);
      check("st_req", mcu_st_vld_o, 1);
      check("st_hold", instr_vld_o, 0);
    end
    idle(ones, 0, 0, 1);
    check("st_issue", instr_vld_o, onehot(B_ST));
    idle(0, 0, 0, 0);
    check("st_popped", q_count_o, 0);

    // unordered indexed load with sew=2
    step(0, 1, ild, 32'h3000, 32'h10, 2, 0, 0, 0, 0);
    idle(ones, 0, 0, 0);
    check("idx_issue", instr_vld_o, onehot(B_LDI));
    idle(0, 1, 1, 0);
    if (SPLIT) begin
      check("idx2_mop", vector_instr_o[27:26], 0);
      check("idx2_width", vector_instr_o[14:12], 3'b010);
      check("idx2_ldreq", mcu_ld_vld_o, 1);
      idle(ones, 0, 0, 0);
      check("idx2_ld_vld", instr_vld_o, onehot(B_LD));
      idle(0, 0, 0, 0);
    end
    check("idx_popped", q_count_o, 0);

    // illegal opcode is dropped in one cycle
    step(0, 1, 32'h0, 32'h5, 32'h6, 0, 0, 0, 0, 0);
    idle(0, 0, 0, 0);
    check("ill_pulse", illegal_o, 1);
    check("ill_count", q_count_o, 1);
    idle(0, 0, 0, 0);
    check("ill_gone", illegal_o, 0);
    check("ill_empty", q_count_o, 0);

    // reset while waiting for load data
    step(0, 1, uld, 32'h44, 32'h4, 0, 0, 0, 0, 0);
    step(0, 1, vadd, 32'h55, 32'h5, 0, 0, 1, 0, 0);
    idle(0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(ones, 1, 1, 1);
    check("rst_mid_count", q_count_o, 0);
    check("rst_mid_vld", instr_vld_o, 0);
    check("rst_mid_ldvld", mcu_ld_vld_o, 0);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic [NU-1:0] rdy;
      rdy = ($urandom_range(0, 3) == 0) ? '0 : NU'($urandom);
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 9) < 6,
           rnd_instr(), $urandom, $urandom,
           2'($urandom), rdy,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
